riscv_dmem_resp: RTL and testbench

Data-memory responder at the far end of the M-stage memory interface of the pipelined RV32I core. It accepts one load/store request at a time: address, write data, byte-lane mask and write enable. It models a configurable number of wait states, performs a byte-lane-masked access on an internal word array, and returns read data with a one-cycle response strobe. While a request is outstanding it stalls the pipeline.

---
 rtl/riscv_dmem_resp_pkg.sv | 35 +++
 rtl/riscv_dmem_array.sv | 33 +++
 rtl/riscv_dmem_resp.sv | 153 +++++++++++++++
 tb/tb_riscv_dmem_resp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_resp_pkg.sv
// Shared constants for the data-memory responder: state encodings,
// default geometry/timing and the set of byte-lane masks an RV32I
// load/store can legally produce.
package riscv_dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEPTH_LOG2  = 10;
    localparam int DMEM_WAIT_CYCLES = 1;

    localparam logic [3:0] DMEM_MASK_B0 = 4'b0001;
    localparam logic [3:0] DMEM_MASK_B1 = 4'b0010;
    localparam logic [3:0] DMEM_MASK_B2 = 4'b0100;
    localparam logic [3:0] DMEM_MASK_B3 = 4'b1000;
    localparam logic [3:0] DMEM_MASK_H0 = 4'b0011;
    localparam logic [3:0] DMEM_MASK_H1 = 4'b1100;
    localparam logic [3:0] DMEM_MASK_W  = 4'b1111;

    // Byte, aligned halfword and full word are the only shapes the M stage emits.
    function automatic logic mask_is_legal(input logic [3:0] mask);
        logic legal;
        legal = 1'b0;
        case (mask)
            DMEM_MASK_B0, DMEM_MASK_B1, DMEM_MASK_B2, DMEM_MASK_B3,
            DMEM_MASK_H0, DMEM_MASK_H1, DMEM_MASK_W: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/riscv_dmem_array.sv
// Word-wide data array with per-lane write enables and a registered read.
// Contents and the read register are deliberately left unreset.
module riscv_dmem_array #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic [3:0]            i_lane_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [XLEN-1:0]       i_wdata,
    output logic [XLEN-1:0]       o_rdata
);
    localparam int LANE_W = XLEN / 4;

    logic [XLEN-1:0] r_mem [2**DEPTH_LOG2];
    logic [XLEN-1:0] r_rdata;

    // Lane-masked write and read of the old word share the single access edge.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int l = 0; l < 4; l++) begin
                if (i_lane_we[l]) begin
                    r_mem[i_idx][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
                end
            end
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the M stage: accepts one request, inserts
// WAIT_CYCLES wait states, performs a lane-masked access and returns a
// one-cycle response while stalling the pipeline in between.
module riscv_dmem_resp
    import riscv_dmem_resp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_LOG2  = DMEM_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    input  logic            i_req_wr_en,
    input  logic [3:0]      i_req_byte_sel,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_req_ready,
    output logic            o_stall,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_err
);
    localparam int LANE_W = XLEN / 4;
    localparam int CNT_W  = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dmem_state_t r_state, w_state_next;

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr_en;
    logic [3:0]            r_byte_sel;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [XLEN-1:0]       r_wdata;
    logic [3:0]            r_rsp_lanes;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_access;
    logic                  w_use_in;
    logic                  w_acc_wr;
    logic [3:0]            w_acc_sel;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [XLEN-1:0]       w_acc_wdata;
    logic                  w_acc_legal;
    logic [3:0]            w_lane_we;
    logic [XLEN-1:0]       w_arr_rdata;
    logic [XLEN-1:0]       w_lane_mask;
    logic                  w_unused_addr;

    assign w_unused_addr = ^{i_req_addr[1:0], i_req_addr[XLEN-1:DEPTH_LOG2+2]};

    // With zero wait states the access happens at the accept edge, so it
    // must use the live request rather than the not-yet-captured copy.
    assign w_accept    = (r_state == DMEM_IDLE) && i_req_valid;
    assign w_access    = ((r_state == DMEM_WAIT) && (r_cnt == '0)) ||
                         (w_accept && (WAIT_CYCLES == 0));
    assign w_use_in    = (r_state == DMEM_IDLE);
    assign w_acc_wr    = w_use_in ? i_req_wr_en    : r_wr_en;
    assign w_acc_sel   = w_use_in ? i_req_byte_sel : r_byte_sel;
    assign w_acc_idx   = w_use_in ? i_req_addr[DEPTH_LOG2+1:2] : r_idx;
    assign w_acc_wdata = w_use_in ? i_req_wdata    : r_wdata;
    assign w_acc_legal = mask_is_legal(w_acc_sel);
    assign w_lane_we   = (w_access && w_acc_wr && w_acc_legal) ? w_acc_sel : 4'b0000;

    riscv_dmem_array #(
        .XLEN       (XLEN),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .i_clk     (i_clk),
        .i_en      (w_access),
        .i_lane_we (w_lane_we),
        .i_idx     (w_acc_idx),
        .i_wdata   (w_acc_wdata),
        .o_rdata   (w_arr_rdata)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DMEM_IDLE: begin
                if (i_req_valid) begin
                    if (WAIT_CYCLES == 0) w_state_next = DMEM_RESP;
                    else                  w_state_next = DMEM_WAIT;
                end
            end
            DMEM_WAIT: if (r_cnt == '0) w_state_next = DMEM_RESP;
            DMEM_RESP: w_state_next = DMEM_IDLE;
            default:   w_state_next = DMEM_IDLE;
        endcase
    end

    // Request capture, wait counter and response qualifiers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_byte_sel  <= 4'b0000;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_rsp_lanes <= 4'b0000;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_en    <= i_req_wr_en;
                r_byte_sel <= i_req_byte_sel;
                r_idx      <= i_req_addr[DEPTH_LOG2+1:2];
                r_wdata    <= i_req_wdata;
                r_cnt      <= CNT_LOAD;
            end else if ((r_state == DMEM_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_rsp_err   <= ~w_acc_legal;
                r_rsp_lanes <= (!w_acc_wr && w_acc_legal) ? w_acc_sel : 4'b0000;
            end
        end
    end

    // Handshake outputs and lane-masked read data.
    always_comb begin
        o_req_ready = 1'b0;
        o_stall     = 1'b0;
        o_rsp_valid = 1'b0;
        if (!i_rst) begin
            case (r_state)
                DMEM_IDLE: begin
                    o_req_ready = 1'b1;
                    o_stall     = i_req_valid;
                end
                DMEM_WAIT: o_stall     = 1'b1;
                DMEM_RESP: o_rsp_valid = 1'b1;
                default: ;
            endcase
        end
        for (int l = 0; l < 4; l++) begin
            w_lane_mask[l*LANE_W +: LANE_W] = {LANE_W{r_rsp_lanes[l]}};
        end
        o_rsp_rdata = w_arr_rdata & w_lane_mask;
        o_rsp_err   = r_rsp_err;
    end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
module tb_riscv_dmem_resp;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        wr_en     [2];
    logic [3:0]  sel       [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        ready     [2];
    logic        stall     [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    always #5 clk = ~clk;

    riscv_dmem_resp #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .i_req_wr_en(wr_en[0]),
        .i_req_byte_sel(sel[0]), .i_req_addr(addr[0]), .i_req_wdata(wdata[0]),
        .o_req_ready(ready[0]), .o_stall(stall[0]), .o_rsp_valid(rsp_valid[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

    riscv_dmem_resp #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .i_req_wr_en(wr_en[1]),
        .i_req_byte_sel(sel[1]), .i_req_addr(addr[1]), .i_req_wdata(wdata[1]),
        .o_req_ready(ready[1]), .o_stall(stall[1]), .o_rsp_valid(rsp_valid[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: word memories plus one outstanding request per DUT.
    logic [31:0] mem [2][1024];
    bit          pend    [2];
    int          p_start [2];
    bit          p_wr    [2];
    logic [3:0]  p_sel   [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] last_rdata [2];
    logic        last_err   [2];

    function automatic int wt(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit legal(input logic [3:0] m);
        return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle, outputs are checked against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                chk("rst_ready", d, 32'(ready[d]), 0);
                chk("rst_stall", d, 32'(stall[d]), 0);
                chk("rst_valid", d, 32'(rsp_valid[d]), 0);
                chk("rst_rdata", d, rsp_rdata[d], 0);
                chk("rst_err", d, 32'(rsp_err[d]), 0);
            end else if (!pend[d]) begin
                chk("idle_ready", d, 32'(ready[d]), 1);
                chk("idle_stall", d, 32'(stall[d]), 0);
                chk("idle_valid", d, 32'(rsp_valid[d]), 0);
            end else begin
                automatic int ph = cyc - p_start[d];
                chk("ready", d, 32'(ready[d]), 32'(ph == 0));
                chk("stall", d, 32'(stall[d]), 32'(ph <= wt(d)));
                chk("valid", d, 32'(rsp_valid[d]), 32'(ph == wt(d) + 1));
                if (ph >= wt(d) + 1) begin
                    automatic int idx = int'(p_addr[d][11:2]);
                    automatic logic [31:0] exp_rd = 0;
                    automatic bit ok = legal(p_sel[d]);
                    if (ok && !p_wr[d]) begin
                        for (int l = 0; l < 4; l++)
                            if (p_sel[d][l]) exp_rd[l*8 +: 8] = mem[d][idx][l*8 +: 8];
                    end
                    if (ok && p_wr[d]) begin
                        for (int l = 0; l < 4; l++)
                            if (p_sel[d][l]) mem[d][idx][l*8 +: 8] = p_wdata[d][l*8 +: 8];
                    end
                    chk("rsp_rdata", d, rsp_rdata[d], exp_rd);
                    chk("rsp_err", d, 32'(rsp_err[d]), 32'(!ok));
                    last_rdata[d] = rsp_rdata[d];
                    last_err[d]   = rsp_err[d];
                    pend[d] = 1'b0;
                end
            end
        end
    end

    // Present a request for one cycle (called just after a rising edge),
    // then scramble the inputs to show the captured copy is what counts.
    task automatic start_req(input int d, input bit w, input logic [3:0] m,
                             input logic [31:0] a, input logic [31:0] wd);
        pend[d] = 1'b1; p_start[d] = cyc;
        p_wr[d] = w; p_sel[d] = m; p_addr[d] = a; p_wdata[d] = wd;
        req_valid[d] = 1'b1; wr_en[d] = w; sel[d] = m; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        wr_en[d] = 1'($urandom); sel[d] = 4'($urandom);
        addr[d] = $urandom; wdata[d] = $urandom;
    endtask

    task automatic issue(input int d, input bit w, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] wd);
        start_req(d, w, m, a, wd);
        for (int k = 0; k < 40 && pend[d]; k++) @(posedge clk);
        #1;
        if (pend[d]) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout dut%0d: got no response, expected one", d);
            pend[d] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; wr_en[d] = 1'b0;
            sel[d] = 4'h0; addr[d] = 0; wdata[d] = 0; pend[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdata", 0, rsp_rdata[0], 0);
        chk("post_rst_ready", 0, 32'(ready[0]), 1);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) issue(d, 1'b1, 4'hF, 32'(i * 4), $urandom);

        issue(0, 1, 4'b1111, 32'h10, 32'hDEADBEEF);
        issue(0, 0, 4'b1111, 32'h10, 0);
        chk("ld_word", 0, last_rdata[0], 32'hDEADBEEF);
        chk("ld_word_err", 0, 32'(last_err[0]), 0);
        issue(0, 1, 4'b0010, 32'h10, 32'h0000AA00);
        issue(0, 0, 4'b1111, 32'h10, 0);
        chk("ld_after_byte", 0, last_rdata[0], 32'hDEADAAEF);
        issue(0, 0, 4'b1100, 32'h10, 0);
        chk("ld_upper_half", 0, last_rdata[0], 32'hDEAD0000);
        issue(0, 1, 4'b1111, 32'h20, 32'hCAFEF00D);
        issue(0, 1, 4'b0101, 32'h20, 32'h11223344);
        chk("bad_mask_err", 0, 32'(last_err[0]), 1);
        chk("bad_mask_rdata", 0, last_rdata[0], 0);
        issue(0, 0, 4'b1111, 32'h20, 0);
        chk("bad_mask_nowrite", 0, last_rdata[0], 32'hCAFEF00D);
        issue(0, 0, 4'b0000, 32'h20, 0);
        chk("zero_mask_err", 0, 32'(last_err[0]), 1);
        issue(0, 1, 4'b1111, 32'h1004, 32'h12345678);
        issue(0, 0, 4'b1111, 32'h0004, 0);
        chk("addr_wrap", 0, last_rdata[0], 32'h12345678);

        issue(1, 1, 4'b1111, 32'h30, 32'h0);
        start_req(1, 1, 4'b1111, 32'h30, 32'hFFFFFFFF);
        @(posedge clk); #1;
        pend[1] = 1'b0;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        issue(1, 0, 4'b1111, 32'h30, 0);
        chk("abort_nowrite", 1, last_rdata[1], 32'h0);

        for (int n = 0; n < 200; n++) begin
            automatic int d = int'($urandom_range(0, 1));
            automatic logic [3:0] lm [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
            automatic logic [3:0] m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : lm[$urandom_range(0, 6)];
            automatic logic [31:0] a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            issue(d, 1'($urandom), m, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
